arbitro_rr8: RTL and testbench

Round-robin arbiter that shares one 3-bit select path among 8 requesters. Each cycle in which the resource is free, it picks the next active requester after the last winner. It drives the winner's index as b2/b1/b0 into the existing 3-to-8 decoder, and the decoder produces the one-hot grant lines. The arbiter holds the grant until the winner drops its request, or, optionally, until a hold limit expires.

---
 rtl/arbitro_rr8_pkg.sv | 11 +
 rtl/arbitro_rr8_decodificador.sv | 23 ++
 rtl/arbitro_rr8.sv | 131 +++++++++++++
 tb/tb_arbitro_rr8.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arbitro_rr8_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arbitro_pkg;
  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/arbitro_rr8_decodificador.sv
// Existing 3-to-8 decoder: b2..b0 select which single e-line is high.
module decodificador (
  input  logic b2,
  input  logic b1,
  input  logic b0,
  output logic e0,
  output logic e1,
  output logic e2,
  output logic e3,
  output logic e4,
  output logic e5,
  output logic e6,
  output logic e7
);
  assign e0 = ~b2 & ~b1 & ~b0;
  assign e1 = ~b2 & ~b1 &  b0;
  assign e2 = ~b2 &  b1 & ~b0;
  assign e3 = ~b2 &  b1 &  b0;
  assign e4 =  b2 & ~b1 & ~b0;
  assign e5 =  b2 & ~b1 &  b0;
  assign e6 =  b2 &  b1 & ~b0;
  assign e7 =  b2 &  b1 &  b0;
endmodule

// File: rtl/arbitro_rr8.sv
// 8-way round-robin arbiter driving the 3-to-8 decoder for one-hot grants.
// Optional hold-limit revocation is enabled by defining ARB_TIMEOUT_EN.
module arbitro_rr8
  import arbitro_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_e           state_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             vld_p0;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] win_idx;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] dec_vec;

  // Rotate so the line after the last winner sits at bit 0, find the lowest
  // set bit, then add the rotation back to recover the absolute index.
  always_comb begin
    start   = idx_p0 + IDX_W'(1);
    dbl     = {req, req} >> start;
    rot     = dbl[N_REQ-1:0];
    off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    win_idx = start + off;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_p0;
  logic              tmo_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      idx_p0   <= '1;
      vld_p0   <= 1'b0;
      hold_p0  <= '0;
      tmo_p0   <= 1'b0;
    end else begin
      tmo_p0 <= 1'b0;
      case (state_p0)
        IDLE: begin
          if (|req) begin
            idx_p0   <= win_idx;
            vld_p0   <= 1'b1;
            hold_p0  <= '0;
            state_p0 <= GRANT;
          end
        end
        GRANT: begin
          // A voluntary release in the limit cycle wins over revocation.
          if (!req[idx_p0]) begin
            vld_p0   <= 1'b0;
            state_p0 <= IDLE;
          end else if (hold_p0 == HOLD_LAST) begin
            vld_p0   <= 1'b0;
            tmo_p0   <= 1'b1;
            state_p0 <= IDLE;
          end else begin
            hold_p0 <= hold_p0 + HOLD_W'(1);
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign timeout = tmo_p0;
`else
  localparam int max_hold_unused = MAX_HOLD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      idx_p0   <= '1;
      vld_p0   <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (|req) begin
            idx_p0   <= win_idx;
            vld_p0   <= 1'b1;
            state_p0 <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx_p0]) begin
            vld_p0   <= 1'b0;
            state_p0 <= IDLE;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  decodificador u_dec (
    .b2 (idx_p0[2]),
    .b1 (idx_p0[1]),
    .b0 (idx_p0[0]),
    .e0 (dec_vec[0]),
    .e1 (dec_vec[1]),
    .e2 (dec_vec[2]),
    .e3 (dec_vec[3]),
    .e4 (dec_vec[4]),
    .e5 (dec_vec[5]),
    .e6 (dec_vec[6]),
    .e7 (dec_vec[7])
  );

  assign gnt       = dec_vec & {N_REQ{vld_p0}};
  assign gnt_idx   = idx_p0;
  assign gnt_valid = vld_p0;

endmodule

// File: tb/tb_arbitro_rr8.sv
// Directed testbench for arbitro_rr8; covers the hold-limit path when ARB_TIMEOUT_EN is defined.
module tb_arbitro_rr8;
  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests;
  int fails;

  arbitro_rr8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    tests++;
    assert (obs === want)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic t);
    chk({tag, ".gnt"},     gnt,              g);
    chk({tag, ".idx"},     {5'd0, gnt_idx},  {5'd0, i});
    chk({tag, ".valid"},   {7'd0, gnt_valid}, {7'd0, v});
    chk({tag, ".timeout"}, {7'd0, timeout},  {7'd0, t});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] one;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset", 8'h00, 3'd7, 1'b0, 1'b0);

    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("idle_noreq", 8'h00, 3'd7, 1'b0, 1'b0);
    end

    // Single requester: grant after one edge, held 3 cycles, released after one edge.
    req = 8'h01;
    tick();
    chk_out("single_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    chk_out("single_hold1", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    chk_out("single_hold2", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("single_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // All lines requesting: rotation 0..7 then wrap to 0.
    do_reset();
    for (int w = 0; w < 9; w++) begin
      one = 8'h01 << (w % 8);
      req = 8'hFF;
      tick();
      chk_out("rr_grant", one, 3'(w % 8), 1'b1, 1'b0);
      tick();
      chk_out("rr_hold", one, 3'(w % 8), 1'b1, 1'b0);
      req = 8'hFF & ~one;
      tick();
      chk_out("rr_idle", 8'h00, 3'(w % 8), 1'b0, 1'b0);
    end

    // Pointer at 5: lines 0 and 5 requesting, 0 wins; 5 follows after 0 releases.
    req = 8'h20;
    tick();
    chk_out("p5_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("p5_release", 8'h00, 3'd5, 1'b0, 1'b0);
    req = 8'h21;
    tick();
    chk_out("p5_win0", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    chk_out("p5_nopreempt", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h20;
    tick();
    chk_out("p5_rel0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("p5_then5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("p5_end", 8'h00, 3'd5, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Hold limit 4: idx 2 then idx 3, each revoked after exactly 4 cycles.
    do_reset();
    req = 8'h0C;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("to_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_revoke2", 8'h00, 3'd2, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("to_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_revoke3", 8'h00, 3'd3, 1'b0, 1'b1);
    req = 8'h00;
    tick();
    chk_out("to_idle", 8'h00, 3'd3, 1'b0, 1'b0);

    // Release coinciding with the limit cycle is a normal release.
    do_reset();
    req = 8'h04;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("to_simul_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    chk_out("to_simul_rel", 8'h00, 3'd2, 1'b0, 1'b0);
`else
    // Without the hold limit a grant lasts as long as the request.
    do_reset();
    req = 8'h0C;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out("nolimit_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    chk_out("nolimit_release", 8'h00, 3'd2, 1'b0, 1'b0);
`endif

    // Reset mid-grant on idx 6 restores reset values; pointer restarts at 7.
    req = 8'h40;
    tick();
    chk_out("rst_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("rst_mid", 8'h00, 3'd7, 1'b0, 1'b0);
    reset = 1'b0;
    req = 8'h41;
    tick();
    chk_out("rst_next0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
